// File: rtl/tmr_pkg.sv
// Shared encodings for the multi-channel compare-match timer: register offsets,
// TCR/TCSR field encodings and bit positions, and the compare-output resolver.
package tmr_pkg;

    localparam logic [2:0] REG_TCNT  = 3'd0;
    localparam logic [2:0] REG_TCORA = 3'd1;
    localparam logic [2:0] REG_TCORB = 3'd2;
    localparam logic [2:0] REG_TCR   = 3'd3;
    localparam logic [2:0] REG_TCSR  = 3'd4;

    typedef enum logic [2:0] {
        CKS_STOP    = 3'd0,
        CKS_CLK     = 3'd1,
        CKS_DIV8    = 3'd2,
        CKS_DIV64   = 3'd3,
        CKS_CASCADE = 3'd4,
        CKS_RISE    = 3'd5,
        CKS_FALL    = 3'd6,
        CKS_BOTH    = 3'd7
    } cks_e;

    typedef enum logic [1:0] {
        CCLR_NONE    = 2'd0,
        CCLR_MATCH_A = 2'd1,
        CCLR_MATCH_B = 2'd2,
        CCLR_TMRI    = 2'd3
    } cclr_e;

    typedef enum logic [1:0] {
        OS_NONE   = 2'd0,
        OS_DRIVE0 = 2'd1,
        OS_DRIVE1 = 2'd2,
        OS_TOGGLE = 2'd3
    } os_e;

    localparam int TCR_CKS_LSB  = 0;
    localparam int TCR_CCLR_LSB = 3;
    localparam int TCR_OVIE     = 5;
    localparam int TCR_CMIEA    = 6;
    localparam int TCR_CMIEB    = 7;

    localparam int TCSR_OSA_LSB = 0;
    localparam int TCSR_OSB_LSB = 2;
    localparam int TCSR_ADTE    = 4;
    localparam int TCSR_OVF     = 5;
    localparam int TCSR_CMFA    = 6;
    localparam int TCSR_CMFB    = 7;

    // When A and B fire together the stronger action wins: toggle, then drive-1, then drive-0.
    function automatic logic os_next(logic cur, logic evt_a, os_e osa, logic evt_b, os_e osb);
        logic tgl;
        logic hi;
        logic lo;
        logic res;
        tgl = (evt_a && osa == OS_TOGGLE) || (evt_b && osb == OS_TOGGLE);
        hi  = (evt_a && osa == OS_DRIVE1) || (evt_b && osb == OS_DRIVE1);
        lo  = (evt_a && osa == OS_DRIVE0) || (evt_b && osb == OS_DRIVE0);
        res = cur;
        if (tgl) begin
            res = ~cur;
        end else if (hi) begin
            res = 1'b1;
        end else if (lo) begin
            res = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/tmr_channel.sv
// One timer channel: up-counter, two compare registers, control/status registers,
// match/overflow event generation and the compare-match output pin.
module tmr_channel
    import tmr_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             tmri_rise,
    input  logic             wr_tcnt,
    input  logic             wr_tcora,
    input  logic             wr_tcorb,
    input  logic             wr_tcr,
    input  logic             wr_tcsr,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] tcnt,
    output logic [CNT_W-1:0] tcora,
    output logic [CNT_W-1:0] tcorb,
    output logic [7:0]       tcr,
    output logic [7:0]       tcsr,
    output logic             ovf_evt,
    output logic             match_a_evt,
    output logic             tmo
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    cclr_e cclr;
    os_e   osa;
    os_e   osb;
    logic  match_b_evt;
    logic  clear_on_tick;

    assign cclr = cclr_e'(tcr[TCR_CCLR_LSB +: 2]);
    assign osa  = os_e'(tcsr[TCSR_OSA_LSB +: 2]);
    assign osb  = os_e'(tcsr[TCSR_OSB_LSB +: 2]);

    // A CPU write to TCNT suppresses every event of that cycle.
    assign match_a_evt   = tick && !wr_tcnt && (tcnt == tcora);
    assign match_b_evt   = tick && !wr_tcnt && (tcnt == tcorb);
    assign ovf_evt       = tick && !wr_tcnt && (tcnt == ALL_ONES);
    assign clear_on_tick = (cclr == CCLR_MATCH_A && match_a_evt)
                         || (cclr == CCLR_MATCH_B && match_b_evt)
                         || ovf_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
        end else if (wr_tcnt) begin
            tcnt <= wdata;
        end else if (cclr == CCLR_TMRI && tmri_rise) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= clear_on_tick ? '0 : tcnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcora <= '1;
            tcorb <= '1;
            tcr   <= '0;
        end else begin
            if (wr_tcora) tcora <= wdata;
            if (wr_tcorb) tcorb <= wdata;
            if (wr_tcr)   tcr   <= wdata[7:0];
        end
    end

    // Flags clear only on a written 0, and a same-cycle hardware set overrides that clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcsr <= '0;
        end else begin
            tcsr[TCSR_CMFB] <= match_b_evt || (tcsr[TCSR_CMFB] && !(wr_tcsr && !wdata[TCSR_CMFB]));
            tcsr[TCSR_CMFA] <= match_a_evt || (tcsr[TCSR_CMFA] && !(wr_tcsr && !wdata[TCSR_CMFA]));
            tcsr[TCSR_OVF]  <= ovf_evt     || (tcsr[TCSR_OVF]  && !(wr_tcsr && !wdata[TCSR_OVF]));
            if (wr_tcsr) tcsr[4:0] <= wdata[4:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo <= 1'b0;
        end else begin
            tmo <= os_next(tmo, match_a_evt, osa, match_b_evt, osb);
        end
    end

endmodule

// File: rtl/multi_channel_timer.sv
// Multi-channel compare-match timer: shared prescaler, pin synchronizers, tick selection,
// cascade wiring between channel pairs, ADC trigger generation and the register bus.
module multi_channel_timer
    import tmr_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = $clog2(NUM_CH) + 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reg_wr,
    input  logic [ADDR_W-1:0]   reg_addr,
    input  logic [CNT_W-1:0]    reg_wdata,
    output logic [CNT_W-1:0]    reg_rdata,
    input  logic [NUM_CH-1:0]   tmci,
    input  logic [NUM_CH-1:0]   tmri,
    output logic [NUM_CH-1:0]   tmo,
    output logic [NUM_CH-1:0]   cmia,
    output logic [NUM_CH-1:0]   cmib,
    output logic [NUM_CH-1:0]   ovi,
    output logic [NUM_CH/2-1:0] adc_req
);

    localparam int CH_W     = ADDR_W - 3;
    localparam int NUM_PAIR = NUM_CH / 2;

    logic [5:0]        presc;
    logic              div8_tick;
    logic              div64_tick;
    logic [NUM_CH-1:0] tmci_s1, tmci_s2, tmci_s3;
    logic [NUM_CH-1:0] tmri_s1, tmri_s2, tmri_s3;
    logic [NUM_CH-1:0] tmci_rise, tmci_fall, tmri_rise;

    logic [CH_W-1:0]   ch_sel;
    logic [2:0]        reg_off;
    logic [NUM_CH-1:0] wr_tcnt, wr_tcora, wr_tcorb, wr_tcr, wr_tcsr;

    logic [CNT_W-1:0]  ch_tcnt  [NUM_CH];
    logic [CNT_W-1:0]  ch_tcora [NUM_CH];
    logic [CNT_W-1:0]  ch_tcorb [NUM_CH];
    logic [7:0]        ch_tcr   [NUM_CH];
    logic [7:0]        ch_tcsr  [NUM_CH];

    function automatic logic sel_tick(cks_e cks, logic casc, logic rise, logic fall,
                                      logic d8, logic d64);
        logic t;
        t = 1'b0;
        case (cks)
            CKS_STOP:    t = 1'b0;
            CKS_CLK:     t = 1'b1;
            CKS_DIV8:    t = d8;
            CKS_DIV64:   t = d64;
            CKS_CASCADE: t = casc;
            CKS_RISE:    t = rise;
            CKS_FALL:    t = fall;
            CKS_BOTH:    t = rise | fall;
            default:     t = 1'b0;
        endcase
        return t;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else begin
            presc <= presc + 6'd1;
        end
    end

    assign div8_tick  = &presc[2:0];
    assign div64_tick = &presc;

    // Third stage is the edge-detect history; clearing it on reset drops edges still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmci_s1 <= '0;
            tmci_s2 <= '0;
            tmci_s3 <= '0;
            tmri_s1 <= '0;
            tmri_s2 <= '0;
            tmri_s3 <= '0;
        end else begin
            tmci_s1 <= tmci;
            tmci_s2 <= tmci_s1;
            tmci_s3 <= tmci_s2;
            tmri_s1 <= tmri;
            tmri_s2 <= tmri_s1;
            tmri_s3 <= tmri_s2;
        end
    end

    assign tmci_rise = tmci_s2 & ~tmci_s3;
    assign tmci_fall = ~tmci_s2 & tmci_s3;
    assign tmri_rise = tmri_s2 & ~tmri_s3;

    assign ch_sel  = reg_addr[ADDR_W-1:3];
    assign reg_off = reg_addr[2:0];

    always_comb begin
        wr_tcnt  = '0;
        wr_tcora = '0;
        wr_tcorb = '0;
        wr_tcr   = '0;
        wr_tcsr  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (reg_wr && ch_sel == CH_W'(i)) begin
                wr_tcnt[i]  = (reg_off == REG_TCNT);
                wr_tcora[i] = (reg_off == REG_TCORA);
                wr_tcorb[i] = (reg_off == REG_TCORB);
                wr_tcr[i]   = (reg_off == REG_TCR);
                wr_tcsr[i]  = (reg_off == REG_TCSR);
            end
        end
    end

    // Per-pair locals keep the even-overflow to odd-tick path free of a vector-wide loop.
    for (genvar k = 0; k < NUM_PAIR; k++) begin : g_pair
        localparam int LO = 2 * k;
        localparam int HI = 2 * k + 1;

        logic tick_lo, tick_hi;
        logic ovf_lo, ovf_hi;
        logic mta_lo, mta_hi;
        logic adc_q;
        logic unused_hi_evts;

        assign tick_lo = sel_tick(cks_e'(ch_tcr[LO][TCR_CKS_LSB +: 3]), 1'b0,
                                  tmci_rise[LO], tmci_fall[LO], div8_tick, div64_tick);
        assign tick_hi = sel_tick(cks_e'(ch_tcr[HI][TCR_CKS_LSB +: 3]), ovf_lo,
                                  tmci_rise[HI], tmci_fall[HI], div8_tick, div64_tick);
        assign unused_hi_evts = ovf_hi ^ mta_hi;

        tmr_channel #(.CNT_W(CNT_W)) u_ch_lo (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick_lo),
            .tmri_rise   (tmri_rise[LO]),
            .wr_tcnt     (wr_tcnt[LO]),
            .wr_tcora    (wr_tcora[LO]),
            .wr_tcorb    (wr_tcorb[LO]),
            .wr_tcr      (wr_tcr[LO]),
            .wr_tcsr     (wr_tcsr[LO]),
            .wdata       (reg_wdata),
            .tcnt        (ch_tcnt[LO]),
            .tcora       (ch_tcora[LO]),
            .tcorb       (ch_tcorb[LO]),
            .tcr         (ch_tcr[LO]),
            .tcsr        (ch_tcsr[LO]),
            .ovf_evt     (ovf_lo),
            .match_a_evt (mta_lo),
            .tmo         (tmo[LO])
        );

        tmr_channel #(.CNT_W(CNT_W)) u_ch_hi (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick_hi),
            .tmri_rise   (tmri_rise[HI]),
            .wr_tcnt     (wr_tcnt[HI]),
            .wr_tcora    (wr_tcora[HI]),
            .wr_tcorb    (wr_tcorb[HI]),
            .wr_tcr      (wr_tcr[HI]),
            .wr_tcsr     (wr_tcsr[HI]),
            .wdata       (reg_wdata),
            .tcnt        (ch_tcnt[HI]),
            .tcora       (ch_tcora[HI]),
            .tcorb       (ch_tcorb[HI]),
            .tcr         (ch_tcr[HI]),
            .tcsr        (ch_tcsr[HI]),
            .ovf_evt     (ovf_hi),
            .match_a_evt (mta_hi),
            .tmo         (tmo[HI])
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                adc_q <= 1'b0;
            end else begin
                adc_q <= mta_lo && ch_tcsr[LO][TCSR_ADTE];
            end
        end

        assign adc_req[k] = adc_q;
    end

    always_comb begin
        cmia = '0;
        cmib = '0;
        ovi  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cmia[i] = ch_tcsr[i][TCSR_CMFA] & ch_tcr[i][TCR_CMIEA];
            cmib[i] = ch_tcsr[i][TCSR_CMFB] & ch_tcr[i][TCR_CMIEB];
            ovi[i]  = ch_tcsr[i][TCSR_OVF]  & ch_tcr[i][TCR_OVIE];
        end
    end

    always_comb begin
        reg_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                case (reg_off)
                    REG_TCNT:  reg_rdata = ch_tcnt[i];
                    REG_TCORA: reg_rdata = ch_tcora[i];
                    REG_TCORB: reg_rdata = ch_tcorb[i];
                    REG_TCR:   reg_rdata = CNT_W'(ch_tcr[i]);
                    REG_TCSR:  reg_rdata = CNT_W'(ch_tcsr[i]);
                    default:   reg_rdata = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer: bus writes at the falling edge, reads and pin
// samples just after it, expected values worked out by hand for each scenario.
module tb_multi_channel_timer;

    logic       clk;
    logic       rst;
    logic       reg_wr;
    logic [4:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic [3:0] tmci;
    logic [3:0] tmri;
    logic [3:0] tmo;
    logic [3:0] cmia;
    logic [3:0] cmib;
    logic [3:0] ovi;
    logic [1:0] adc_req;

    int checkCount = 0;
    int passCount  = 0;

    localparam logic [2:0] TCNT  = 3'd0;
    localparam logic [2:0] TCORA = 3'd1;
    localparam logic [2:0] TCORB = 3'd2;
    localparam logic [2:0] TCR   = 3'd3;
    localparam logic [2:0] TCSR  = 3'd4;

    multi_channel_timer dut (
        .clk       (clk),
        .rst       (rst),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .tmci      (tmci),
        .tmri      (tmri),
        .tmo       (tmo),
        .cmia      (cmia),
        .cmib      (cmib),
        .ovi       (ovi),
        .adc_req   (adc_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Bus write: strobe is held across exactly one rising edge; returns on the next falling edge.
    task automatic applyStimulus(input int ch, input logic [2:0] off, input logic [7:0] data);
        reg_addr  = {2'(ch), off};
        reg_wdata = data;
        reg_wr    = 1'b1;
        @(negedge clk);
        reg_wr    = 1'b0;
    endtask

    task automatic readReg(input int ch, input logic [2:0] off, output logic [7:0] data);
        reg_addr = {2'(ch), off};
        #1;
        data = reg_rdata;
    endtask

    task automatic checkReg(input string tag, input int ch, input logic [2:0] off, input logic [7:0] expected);
        logic [7:0] d;
        readReg(ch, off, d);
        checkOutput(tag, 32'(d), 32'(expected));
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        reg_wr    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        tmci      = '0;
        tmri      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset state");
        checkReg("rst_tcnt0", 0, TCNT, 8'h00);
        checkReg("rst_tcora1", 1, TCORA, 8'hFF);
        checkReg("rst_tcorb3", 3, TCORB, 8'hFF);
        checkReg("rst_tcr2", 2, TCR, 8'h00);
        checkReg("rst_tcsr0", 0, TCSR, 8'h00);
        checkReg("rst_off5", 3, 3'd5, 8'h00);
        checkOutput("rst_tmo", 32'(tmo), 32'h0);
        checkOutput("rst_adc", 32'(adc_req), 32'h0);
        checkOutput("rst_irq", 32'({cmia, cmib, ovi}), 32'h0);

        $display("[TB] compare-match A clear with toggle output");
        resetDut();
        applyStimulus(0, TCORA, 8'd4);
        applyStimulus(0, TCSR, 8'h03);
        applyStimulus(0, TCR, 8'h09);
        for (int i = 0; i < 11; i++) begin
            checkReg($sformatf("cm_tcnt_%0d", i), 0, TCNT, 8'(i % 5));
            checkOutput($sformatf("cm_tmo_%0d", i), 32'(tmo[0]), 32'((i / 5) % 2));
            @(negedge clk);
        end
        checkReg("cm_tcsr_cmfa", 0, TCSR, 8'h43);

        $display("[TB] overflow flag and interrupt");
        resetDut();
        applyStimulus(0, TCNT, 8'hFE);
        applyStimulus(0, TCR, 8'h01);
        checkReg("ovf_fe", 0, TCNT, 8'hFE);
        @(negedge clk);
        checkReg("ovf_ff", 0, TCNT, 8'hFF);
        @(negedge clk);
        checkReg("ovf_wrap", 0, TCNT, 8'h00);
        checkReg("ovf_flags", 0, TCSR, 8'hE0);
        checkOutput("ovf_ovi_off", 32'(ovi[0]), 32'h0);
        applyStimulus(0, TCR, 8'h21);
        checkOutput("ovf_ovi_on", 32'(ovi[0]), 32'h1);
        applyStimulus(0, TCSR, 8'hDF);
        checkReg("ovf_clear", 0, TCSR, 8'hDF);
        checkOutput("ovf_ovi_cleared", 32'(ovi[0]), 32'h0);

        $display("[TB] cascade pair");
        resetDut();
        applyStimulus(0, TCNT, 8'hFF);
        applyStimulus(1, TCR, 8'h04);
        applyStimulus(2, TCR, 8'h04);
        applyStimulus(0, TCR, 8'h01);
        checkReg("casc_lo_start", 0, TCNT, 8'hFF);
        checkReg("casc_hi_start", 1, TCNT, 8'h00);
        @(negedge clk);
        checkReg("casc_lo_wrap", 0, TCNT, 8'h00);
        checkReg("casc_hi_inc", 1, TCNT, 8'h01);
        repeat (256) @(negedge clk);
        checkReg("casc_lo_256", 0, TCNT, 8'h00);
        checkReg("casc_hi_256", 1, TCNT, 8'h02);
        applyStimulus(0, TCR, 8'h00);
        checkReg("casc_lo_stop", 0, TCNT, 8'h01);
        repeat (300) @(negedge clk);
        checkReg("casc_lo_frozen", 0, TCNT, 8'h01);
        checkReg("casc_hi_frozen", 1, TCNT, 8'h02);
        checkReg("casc_even_stop", 2, TCNT, 8'h00);

        $display("[TB] external count clock");
        resetDut();
        applyStimulus(0, TCR, 8'h05);
        tmci[0] = 1'b1;
        @(negedge clk);
        checkReg("ext_lat1", 0, TCNT, 8'h00);
        @(negedge clk);
        checkReg("ext_lat2", 0, TCNT, 8'h00);
        @(negedge clk);
        checkReg("ext_lat3", 0, TCNT, 8'h01);
        @(negedge clk);
        tmci[0] = 1'b0;
        repeat (6) @(negedge clk);
        checkReg("ext_rise_only", 0, TCNT, 8'h01);
        applyStimulus(0, TCR, 8'h07);
        tmci[0] = 1'b1;
        repeat (4) @(negedge clk);
        tmci[0] = 1'b0;
        repeat (6) @(negedge clk);
        checkReg("ext_both_edges", 0, TCNT, 8'h03);

        $display("[TB] same-cycle priorities");
        resetDut();
        applyStimulus(0, TCNT, 8'hFE);
        applyStimulus(0, TCR, 8'h01);
        @(negedge clk);
        applyStimulus(0, TCSR, 8'h00);
        checkReg("pri_set_wins", 0, TCSR, 8'hE0);
        resetDut();
        applyStimulus(0, TCR, 8'h01);
        applyStimulus(0, TCNT, 8'h40);
        checkReg("pri_wr_beats_tick", 0, TCNT, 8'h40);
        @(negedge clk);
        checkReg("pri_after_wr", 0, TCNT, 8'h41);
        resetDut();
        applyStimulus(0, TCORA, 8'd3);
        applyStimulus(0, TCORB, 8'd3);
        applyStimulus(0, TCSR, 8'h0D);
        applyStimulus(0, TCR, 8'h09);
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput($sformatf("pri_tmo_%0d", i), 32'(tmo[0]), 32'((i >= 4 && i < 8) ? 1 : 0));
            @(negedge clk);
        end

        $display("[TB] ADC trigger and mid-count reset");
        resetDut();
        applyStimulus(0, TCORA, 8'd2);
        applyStimulus(0, TCSR, 8'h13);
        applyStimulus(0, TCR, 8'h49);
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput($sformatf("adc_%0d", i), 32'(adc_req), 32'((i > 0 && i % 3 == 0) ? 1 : 0));
            @(negedge clk);
        end
        #1;
        checkOutput("adc_pre_tmo", 32'(tmo[0]), 32'h1);
        checkOutput("adc_pre_cmia", 32'(cmia[0]), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkReg("mid_rst_tcnt", 0, TCNT, 8'h00);
        checkReg("mid_rst_tcora", 0, TCORA, 8'hFF);
        checkReg("mid_rst_tcsr", 0, TCSR, 8'h00);
        checkOutput("mid_rst_tmo", 32'(tmo), 32'h0);
        checkOutput("mid_rst_adc", 32'(adc_req), 32'h0);
        checkOutput("mid_rst_cmia", 32'(cmia), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
